core_msg_rx: RTL
================

# core_msg_rx

Core-side receiver for the scheduler's task broadcast stream: one instance per shader core. It samples the 16-bit `mess_to_core` bus with its four loading strobes and decides whether the broadcast task belongs to this core. If it does, it captures the R0 init bit and the R0 data words and writes instruction words into the core's instruction memory. When loading is complete it hands off execution. It drives this core's bits of the scheduler's `core_reading` and `core_ready` inputs.

## Interface
- `CORE_ID`, 0: index of this core in the 16-bit core mask and R0 mask.
- `MSG_WIDTH`, 16: width of `mess_to_core` and of one instruction word.
- `R0_WORDS`, 8: number of R0 data words per task (R0 value is `R0_WORDS*MSG_WIDTH` = 128 bits).
- `IMEM_DEPTH`, 256: instruction memory depth in words; address width is `$clog2(IMEM_DEPTH)`.
- `END_GAP`, 4: number of consecutive strobe-free cycles in LOAD that ends the instruction stream.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `mess_to_core`  in  16  broadcast message word.
- `core_mask_loading`  in  1  word is the task core mask.
- `r0_mask_loading`  in  1  word is the R0 init vector.
- `r0_loading`  in  1  word is an R0 data word.
- `instr_loading`  in  1  word is an instruction.
- `core_done`  in  1  single-cycle pulse from the core when execution of the task has finished.
- `core_reading`  out  1  this core accepts stream words.
- `core_ready`  out  1  this core is idle (scheduler exec_mask = ~ready).
- `r0_init`  out  1  R0 of this core is initialised by the task.
- `r0_value`  out  128  captured R0 data; word k is at bits [16k+15:16k].
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  log2(IMEM_DEPTH)  write address.
- `imem_wdata`  out  16  write data.
- `instr_count`  out  log2(IMEM_DEPTH)+1  instructions stored for the current task.
- `task_start`  out  1  single-cycle pulse at the start of execution.
- `rx_err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- Reset values: all outputs 0 except `core_reading`=1 and `core_ready`=1. Counters are 0 and `r0_value` is 0.
- The strobes and `mess_to_core` are registered by the scheduler and sampled together on the same `clk` edge. The strobes are expected to be one-hot.
- Multiple strobes in one cycle: the highest-priority strobe is processed and `rx_err` is set. Priority order is core_mask > r0_mask > r0 > instr.
- IDLE, on `core_mask_loading`:
  - If `mess_to_core[CORE_ID]`=1: go to LOAD, clear `r0_init`, `r0_value`, the R0 word index and `instr_count`.
  - Otherwise stay in IDLE and ignore all following strobes until the next core mask.
- LOAD, on `r0_mask_loading`: `r0_init` <= `mess_to_core[CORE_ID]`.
- LOAD, on `r0_loading`:
  - If `r0_init`=1, write the word to R0 word[index].
  - The index increments regardless of `r0_init`.
  - A word with index ≥ `R0_WORDS` is dropped and sets `rx_err`.
- LOAD, on `instr_loading`:
  - `imem_we`=1, `imem_addr`=`instr_count`, `imem_wdata`=`mess_to_core`; `instr_count` increments.
  - When `instr_count`=`IMEM_DEPTH`, the word is dropped, `rx_err` is set, and there is no wrap-around.
- LOAD ends and the block goes to RUN on either condition:
  - `END_GAP` consecutive cycles without any strobe, provided `instr_count`>0.
  - `core_mask_loading` (the next task's mask). If that mask has bit CORE_ID set, set `rx_err`; the mask is otherwise ignored.
- LOAD with `instr_count`=0 never times out.
- RUN: strobes are ignored. A `core_mask_loading` with bit CORE_ID set sets `rx_err`. `core_done` returns the block to IDLE.
- `core_done` outside RUN is ignored.
- Outputs by state:
  - `core_reading` = 1 in IDLE and LOAD, 0 in RUN.
  - `core_ready` = 1 only in IDLE.
- `rx_err` is cleared only by reset.

## Timing
- Registered outputs, 1-cycle latency: a strobe sampled at edge N produces `imem_*`, `r0_*` and `instr_count` updates after edge N.
- `imem_we` is a 1-cycle pulse per instruction word.
- `task_start` pulses in the first RUN cycle. This is the cycle after the gap counter reaches `END_GAP`, or the cycle after the next-mask strobe.
- The gap counter resets on any strobe. A scheduler stall shorter than `END_GAP` cycles does not end LOAD.
- `core_reading` falls in the same cycle `task_start` rises.
- `core_done` sampled at edge N puts the block in IDLE after edge N, with `core_reading`=`core_ready`=1.
- Asynchronous reset mid-LOAD or mid-RUN: IDLE immediately and all state cleared. Partially written imem contents are not cleaned.

## Configuration
- `CORE_RX_ERR_EN` defined: error detection as specified and `rx_err` is live.
- `CORE_RX_ERR_EN` undefined: `rx_err` is tied to 0 and the error logic is removed. Overflow words are still dropped, multi-strobe priority still applies, and all other behaviour is identical.

## Test plan
- CORE_ID=3, sequence:
  - mask 0x0008
  - r0 mask 0x0008
  - 8 R0 words 0x1000..0x1007
  - 16 instr 0xA000..0xA00F
  - 4 idle cycles

  Expected: `r0_init`=1, `r0_value`=0x1007…1000, 16 imem writes to addresses 0..15, `instr_count`=16, `task_start` one cycle after the 4th idle cycle.
- Mask 0x0004 to CORE_ID=3 -> stays IDLE; no `imem_we`; `r0_value`=0; `core_ready` stays 1.
- r0 mask 0x0000 with 8 R0 words -> `r0_init`=0, `r0_value` remains 0, R0 index reaches 8.
- Load 5 instr, then mask 0x0010 on the next cycle -> RUN with `task_start` the next cycle, `rx_err`=0. Repeat with mask 0x0018 -> `rx_err`=1.
- IMEM_DEPTH=4 and 6 instr words -> 4 writes, `instr_count`=4, `rx_err`=1 (0 if `CORE_RX_ERR_EN` undefined).
- `reset_n` low during the 3rd R0 word -> outputs at their reset values immediately; a subsequent full task loads correctly.

Source files
------------

// File: rtl/core_msg_rx.sv
// Per-core receiver for the scheduler task broadcast: filters tasks by core mask, captures R0, writes imem, starts execution.
// Latency: one cycle from a sampled strobe to the imem_*/r0_*/instr_count update; task_start is a registered pulse.
// Backpressure: none, the stream is never stalled; core_reading/core_ready only report status back to the scheduler.
//
// Optional feature macro: CORE_RX_ERR_EN (defined -> sticky rx_err protocol checking; undefined -> rx_err tied 0).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mess_to_core                 broadcast word, qualified by one of four loading strobes
//   core_mask_loading            word is the task core mask
//   r0_mask_loading              word is the R0 init vector
//   r0_loading / instr_loading   word is an R0 data word / an instruction
//   core_done                    end-of-execution pulse from the core
//   core_reading, core_ready     status back to the scheduler (IDLE/LOAD, IDLE)
//   r0_init, r0_value            captured R0 init flag and R0 data (word k at [16k+15:16k])
//   imem_we/imem_addr/imem_wdata instruction memory write port
//   instr_count                  instructions stored for the current task
//   task_start                   one-cycle pulse in the first RUN cycle
//   rx_err                       sticky protocol-error flag
module core_msg_rx #(
  parameter int CORE_ID    = 0,
  parameter int MSG_WIDTH  = 16,
  parameter int R0_WORDS   = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int END_GAP    = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [MSG_WIDTH-1:0]            mess_to_core,
  input  logic                            core_mask_loading,
  input  logic                            r0_mask_loading,
  input  logic                            r0_loading,
  input  logic                            instr_loading,
  input  logic                            core_done,
  output logic                            core_reading,
  output logic                            core_ready,
  output logic                            r0_init,
  output logic [R0_WORDS*MSG_WIDTH-1:0]   r0_value,
  output logic                            imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0]   imem_addr,
  output logic [MSG_WIDTH-1:0]            imem_wdata,
  output logic [$clog2(IMEM_DEPTH):0]     instr_count,
  output logic                            task_start,
  output logic                            rx_err
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int IW = $clog2(R0_WORDS + 1);
  localparam int GW = $clog2(END_GAP + 1);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(IMEM_DEPTH);
  localparam logic [IW-1:0] R0_END   = IW'(R0_WORDS);
  localparam logic [GW-1:0] GAP_LAST = GW'(END_GAP - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(END_GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] r0_idx;
  logic [GW-1:0] gap_cnt;

  // Priority-decoded strobes: at most one of these is set in any cycle.
  logic stb_mask, stb_r0m, stb_r0, stb_ins, stb_any;
  logic mine;
  logic r0_full, imem_full;

  assign stb_mask = core_mask_loading;
  assign stb_r0m  = r0_mask_loading & ~core_mask_loading;
  assign stb_r0   = r0_loading & ~r0_mask_loading & ~core_mask_loading;
  assign stb_ins  = instr_loading & ~r0_loading & ~r0_mask_loading & ~core_mask_loading;
  assign stb_any  = core_mask_loading | r0_mask_loading | r0_loading | instr_loading;
  assign mine     = mess_to_core[CORE_ID];

  // Indices saturate at their end values, so "full" also means "word is dropped".
  assign r0_full   = (r0_idx == R0_END);
  assign imem_full = (instr_count == DEPTH_C);

  logic start_task, go_run, take_r0m, take_r0, take_ins;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_task = 1'b0;
    go_run     = 1'b0;
    take_r0m   = 1'b0;
    take_r0    = 1'b0;
    take_ins   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Other strobes in IDLE belong to a task for other cores.
        if (stb_mask && mine) begin
          state_nxt  = ST_LOAD;
          start_task = 1'b1;
        end
      end
      ST_LOAD: begin
        if (stb_mask) begin
          // Next task's mask closes our load regardless of its content.
          state_nxt = ST_RUN;
          go_run    = 1'b1;
        end else if (stb_r0m) begin
          take_r0m = 1'b1;
        end else if (stb_r0) begin
          take_r0 = !r0_full;
        end else if (stb_ins) begin
          take_ins = !imem_full;
        end else if (gap_cnt >= GAP_LAST && instr_count != '0) begin
          // This idle cycle completes the END_GAP-long quiet period.
          state_nxt = ST_RUN;
          go_run    = 1'b1;
        end
      end
      ST_RUN: begin
        if (core_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign core_reading = (state != ST_RUN);
  assign core_ready   = (state == ST_IDLE);

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_init     <= 1'b0;
      r0_value    <= '0;
      r0_idx      <= '0;
      instr_count <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      task_start  <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      imem_we    <= take_ins;
      task_start <= go_run;

      if (start_task) begin
        r0_init     <= 1'b0;
        r0_value    <= '0;
        r0_idx      <= '0;
        instr_count <= '0;
      end

      if (take_r0m) r0_init <= mine;

      if (take_r0) begin
        // Index advances even when R0 is not initialised, keeping word
        // positions aligned with the broadcast order.
        r0_idx <= r0_idx + IW'(1);
        for (int k = 0; k < R0_WORDS; k++) begin
          if (r0_init && r0_idx == IW'(k))
            r0_value[k*MSG_WIDTH +: MSG_WIDTH] <= mess_to_core;
        end
      end

      if (take_ins) begin
        imem_addr   <= instr_count[AW-1:0];
        imem_wdata  <= mess_to_core;
        instr_count <= instr_count + (AW+1)'(1);
      end

      // Quiet-cycle counter only runs inside LOAD; any strobe restarts it.
      if (state == ST_LOAD && !stb_any) begin
        if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Protocol error detection
  // ------------------------------------------------------------------
`ifdef CORE_RX_ERR_EN
  logic [3:0] stb_vec;
  logic       multi_stb;
  logic       err_set;

  assign stb_vec   = {core_mask_loading, r0_mask_loading, r0_loading, instr_loading};
  assign multi_stb = (stb_vec & (stb_vec - 4'd1)) != 4'd0;

  // A mask naming this core while it is busy means the scheduler lost track of us.
  assign err_set = multi_stb
                 | (state != ST_IDLE && stb_mask && mine)
                 | (state == ST_LOAD && stb_r0 && r0_full)
                 | (state == ST_LOAD && stb_ins && imem_full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rx_err <= 1'b0;
    else if (err_set) rx_err <= 1'b1;
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule
